mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the memory address register and the RAM for two requesters: instruction fetch and data load/store.
//  Arbitrates between the two, loads the MAR through its write strobe, waits out the RAM latency, then performs the transfer.
//  Completion is signalled to the requester that was granted.
//  Sits between the control unit / program counter and the mar + RAM datapath.
// PARAMETERS
//  ADDR_W   8   MAR / RAM address width
//  DATA_W   16  bus and RAM data width; MAR takes the low ADDR_W bits
//  RAM_LAT  1   cycles from MAR update to valid ram_rdata (>=1)
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  fetch_req    in   1        fetch request; held until fetch_gnt
//  fetch_addr   in   ADDR_W   fetch address (always a read)
//  fetch_gnt    out  1        1-cycle pulse: fetch accepted
//  fetch_done   out  1        1-cycle pulse: fetch_rdata valid
//  data_req     in   1        data request; held until data_gnt
//  data_we      in   1        1=store, 0=load
//  data_addr    in   ADDR_W   data address
//  data_wdata   in   DATA_W   store data
//  data_gnt     out  1        1-cycle pulse: data request accepted
//  data_done    out  1        1-cycle pulse: load data valid / store committed
//  rdata        out  DATA_W   registered read data; shared by both requesters
//  mar_write    out  1        MAR load strobe
//  mar_bus      out  DATA_W   value driven to the MAR bus input: {zeros, addr}
//  mar_q        in   ADDR_W   MAR output, monitored for protocol check only
//  ram_we       out  1        RAM write enable
//  ram_wdata    out  DATA_W   RAM write data
//  ram_rdata    in   DATA_W   RAM read data
//  busy         out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset values:
//   - FSM goes to IDLE; all outputs are 0; rdata = 0.
//   - Round-robin pointer last = DATA, so fetch wins the first tie.
//  FSM states and transitions:
//   - IDLE -> ADDR when any req=1.
//   - ADDR (1 cycle) -> WAIT.
//   - WAIT (RAM_LAT cycles, down-counter) -> XFER.
//   - XFER (1 cycle) -> DONE.
//   - DONE (1 cycle) -> IDLE.
//  Arbitration, evaluated in IDLE only:
//   - Only one request pending: it wins.
//   - Both pending: the one not served last wins. `last` updates on grant.
//  Grant and latching:
//   - gnt of the winner pulses in the ADDR cycle.
//   - addr, we and wdata are latched on IDLE->ADDR. Requester inputs are ignored after that.
//  ADDR cycle:
//   - mar_write = 1; mar_bus = {{DATA_W-ADDR_W{1'b0}}, latched addr}.
//   - mar_q shows addr from the next cycle.
//  XFER cycle:
//   - Store: ram_we = 1 and ram_wdata = latched wdata for exactly this cycle.
//   - Load/fetch: ram_rdata is sampled into rdata at the end of the cycle.
//  DONE cycle:
//   - The granted requester's done = 1; rdata is valid and holds until the next read completes.
//   - A store leaves rdata unchanged.
//  Latency:
//   - Request seen in cycle 0 gives gnt in cycle 1 and done in cycle 3+RAM_LAT. Stores take the same timing.
//   - Back-to-back transactions pass through one IDLE cycle, so each takes 4+RAM_LAT cycles.
//  Outside these windows:
//   - mar_write = 0, ram_we = 0, mar_bus = 0.
//   - mar_write and ram_we are never high in the same cycle.
//  Requester protocol:
//   - A req dropped before gnt is withdrawn; no transaction occurs.
//   - A req still high in the IDLE cycle after DONE is a new request.
//  Reset mid-operation:
//   - The next edge returns the FSM to IDLE with all outputs 0.
//   - The in-flight transaction is abandoned: no done, no further ram_we.
//   - The RAM contents of a store whose XFER has not yet occurred are untouched.
// TESTING
//  1. Fetch read, RAM_LAT=1: fetch_req@c0, fetch_addr=8'h3A.
//     -> mar_write@c1 with mar_bus=16'h003A; mar_q=8'h3A@c2.
//     -> fetch_done@c4 with rdata=mem[8'h3A]=16'hBEEF.
//  2. Store: data_req, data_we=1, data_addr=8'h10, data_wdata=16'h1234.
//     -> ram_we high for exactly 1 cycle (c3); a later load of 8'h10 returns 16'h1234.
//     -> data_done@c4; rdata unchanged.
//  3. Simultaneous fetch_req and data_req held high after reset.
//     -> grants alternate fetch, data, fetch; done pulses at 5-cycle spacing.
//  4. RAM_LAT=3: data load.
//     -> gnt@c1, done@c6; no ram_we during the whole transaction.
//  5. rst asserted in the WAIT cycle of a store.
//     -> next cycle: busy=0, ram_we never asserted, no done; memory location unchanged.
//  6. data_req pulsed for one cycle while a fetch is in flight.
//     -> no data_gnt, no data_done; only the fetch completes.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates instruction fetch against data load/store,
// loads the MAR, waits out the RAM latency, then performs the single transfer.
module mem_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mar_write,
  output logic [DATA_W-1:0] mar_bus,
  input  logic [ADDR_W-1:0] mar_q,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_XFER, ST_DONE} state_e;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_e;

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_e             state_q, state_d;
  src_e               last_q, last_d;
  src_e               sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= SRC_DATA;
      sel_q   <= SRC_FETCH;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the request payload is always re-latched before it is observed,
  // so these registers carry no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req || data_req) begin
          // On a tie, the requester not served last wins.
          if (fetch_req && (!data_req || last_q == SRC_DATA)) begin
            sel_d  = SRC_FETCH;
            addr_d = fetch_addr;
            we_d   = 1'b0;
          end else begin
            sel_d  = SRC_DATA;
            addr_d = data_addr;
            we_d   = data_we;
          end
          wdata_d = data_wdata;
          last_d  = sel_d;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = CNT_W'(RAM_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_XFER;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_XFER: begin
        if (!we_q) rdata_d = ram_rdata;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_gnt  = 1'b0;
    data_gnt   = 1'b0;
    fetch_done = 1'b0;
    data_done  = 1'b0;
    mar_write  = 1'b0;
    mar_bus    = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    unique case (state_q)
      ST_ADDR: begin
        mar_write = 1'b1;
        mar_bus   = DATA_W'(addr_q);
        fetch_gnt = (sel_q == SRC_FETCH);
        data_gnt  = (sel_q == SRC_DATA);
      end
      ST_XFER: begin
        ram_we    = we_q;
        ram_wdata = we_q ? wdata_q : '0;
      end
      ST_DONE: begin
        fetch_done = (sel_q == SRC_FETCH);
        data_done  = (sel_q == SRC_DATA);
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != ST_IDLE);

  // The MAR must hold the latched address for the whole wait window.
  mar_tracks_addr: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_WAIT) |-> (mar_q == addr_q));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: one instance at RAM_LAT=1, one at RAM_LAT=3,
// each with a behavioural MAR + RAM model.
module tb_mem_access_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    bit          is_fetch;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic          fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [AW-1:0] fetch_addr = '0, data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          fetch_gnt, fetch_done, data_gnt, data_done, mar_write, ram_we, busy;
  logic [DW-1:0] rdata, mar_bus, ram_wdata, ram_rdata;
  logic [AW-1:0] mar_q;

  logic          fetch_req3 = 1'b0, data_req3 = 1'b0, data_we3 = 1'b0;
  logic [AW-1:0] fetch_addr3 = '0, data_addr3 = '0;
  logic [DW-1:0] data_wdata3 = '0;
  logic          fetch_gnt3, fetch_done3, data_gnt3, data_done3, mar_write3, ram_we3, busy3;
  logic [DW-1:0] rdata3, mar_bus3, ram_wdata3, ram_rdata3;
  logic [AW-1:0] mar_q3;

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] mem3 [256];
  logic [AW-1:0] mar = '0, mar3 = '0;

  exp_t gnt_q[$], done_q[$], gnt3_q[$], done3_q[$];
  int   we_cnt = 0, we_cyc = -1, done_cnt = 0, data_gnt_cnt = 0, we3_cnt = 0;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_done(data_done), .rdata(rdata),
    .mar_write(mar_write), .mar_bus(mar_bus), .mar_q(mar_q),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req3), .fetch_addr(fetch_addr3), .fetch_gnt(fetch_gnt3), .fetch_done(fetch_done3),
    .data_req(data_req3), .data_we(data_we3), .data_addr(data_addr3), .data_wdata(data_wdata3),
    .data_gnt(data_gnt3), .data_done(data_done3), .rdata(rdata3),
    .mar_write(mar_write3), .mar_bus(mar_bus3), .mar_q(mar_q3),
    .ram_we(ram_we3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAR registers and combinational-read RAMs
  assign mar_q      = mar;
  assign ram_rdata  = mem[mar];
  assign mar_q3     = mar3;
  assign ram_rdata3 = mem3[mar3];
  always @(posedge clk) begin
    if (mar_write)  mar  <= mar_bus[AW-1:0];
    if (ram_we)     mem[mar] <= ram_wdata;
    if (mar_write3) mar3 <= mar_bus3[AW-1:0];
    if (ram_we3)    mem3[mar3] <= ram_wdata3;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the RAM_LAT=1 instance
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (fetch_gnt || data_gnt) begin
        if (data_gnt) data_gnt_cnt++;
        if (gnt_q.size() == 0) check("unexpected_gnt", {fetch_gnt, data_gnt}, 2'b00);
        else begin
          e = gnt_q.pop_front();
          check("gnt_who", {fetch_gnt, data_gnt}, e.is_fetch ? 2'b10 : 2'b01);
          check("gnt_cycle", cyc, e.cyc);
        end
      end
      if (fetch_done || data_done) begin
        done_cnt++;
        if (done_q.size() == 0) check("unexpected_done", {fetch_done, data_done}, 2'b00);
        else begin
          e = done_q.pop_front();
          check("done_who", {fetch_done, data_done}, e.is_fetch ? 2'b10 : 2'b01);
          check("done_cycle", cyc, e.cyc);
          check("done_rdata", rdata, e.rdata);
        end
      end
      if (mar_write || ram_we) check("mar_we_exclusive", mar_write & ram_we, 0);
      if (ram_we) begin
        we_cnt++;
        we_cyc = cyc;
      end
    end
  end

  // Monitor for the RAM_LAT=3 instance
  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst) begin
      if (fetch_gnt3 || data_gnt3) begin
        if (gnt3_q.size() == 0) check("unexpected_gnt3", {fetch_gnt3, data_gnt3}, 2'b00);
        else begin
          e = gnt3_q.pop_front();
          check("gnt3_who", {fetch_gnt3, data_gnt3}, e.is_fetch ? 2'b10 : 2'b01);
          check("gnt3_cycle", cyc, e.cyc);
        end
      end
      if (fetch_done3 || data_done3) begin
        if (done3_q.size() == 0) check("unexpected_done3", {fetch_done3, data_done3}, 2'b00);
        else begin
          e = done3_q.pop_front();
          check("done3_who", {fetch_done3, data_done3}, e.is_fetch ? 2'b10 : 2'b01);
          check("done3_cycle", cyc, e.cyc);
          check("done3_rdata", rdata3, e.rdata);
        end
      end
      if (ram_we3) we3_cnt++;
    end
  end

  task automatic push_gnt(input bit is_fetch, input int c);
    exp_t e;
    e.is_fetch = is_fetch; e.rdata = '0; e.cyc = c;
    gnt_q.push_back(e);
  endtask

  task automatic push_done(input bit is_fetch, input logic [15:0] rd, input int c);
    exp_t e;
    e.is_fetch = is_fetch; e.rdata = rd; e.cyc = c;
    done_q.push_back(e);
  endtask

  // Caller is just after a posedge; request is sampled at the next edge.
  task automatic start_txn(input bit is_fetch, input bit we, input logic [7:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rd, output int n0);
    n0 = cyc;
    if (is_fetch) begin
      fetch_req = 1'b1; fetch_addr = addr;
    end else begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
    end
    push_gnt(is_fetch, n0 + 1);
    push_done(is_fetch, exp_rd, n0 + 4);
  endtask

  task automatic wait_gnt(input bit is_fetch);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_fetch ? fetch_gnt : data_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("gnt_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) check("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_txn(input bit is_fetch, input bit we, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
    int n0;
    start_txn(is_fetch, we, addr, wdata, exp_rd, n0);
    wait_gnt(is_fetch);
    @(posedge clk); #1;
    fetch_req = 1'b0; data_req = 1'b0;
    wait_idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n0, we0, done0, dg0;
    bit seen;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      mem3[i] = '0;
    end
    mem[8'h3A] = 16'hBEEF;
    mem[8'h20] = 16'hCAFE;
    mem[8'h21] = 16'hF00D;
    mem[8'h55] = 16'h5555;
    mem3[8'h44] = 16'h4444;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_mar_write", mar_write, 0);
    check("rst_mar_bus", mar_bus, 16'h0);
    check("rst_ram_we", ram_we, 0);
    check("rst_gnt_done", {fetch_gnt, data_gnt, fetch_done, data_done}, 4'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. Fetch read at 8'h3A
    start_txn(1'b1, 1'b0, 8'h3A, 16'h0, 16'hBEEF, n0);
    @(negedge clk);
    @(negedge clk);
    check("t1_mar_write_c1", mar_write, 1);
    check("t1_mar_bus_c1", mar_bus, 16'h003A);
    check("t1_busy_c1", busy, 1);
    @(negedge clk);
    check("t1_mar_q_c2", mar_q, 8'h3A);
    check("t1_mar_write_c2", mar_write, 0);
    check("t1_mar_bus_c2", mar_bus, 16'h0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    wait_idle();

    // 2. Store 16'h1234 to 8'h10, then load it back
    we0 = we_cnt;
    start_txn(1'b0, 1'b1, 8'h10, 16'h1234, 16'hBEEF, n0);
    wait_gnt(1'b0);
    @(posedge clk); #1;
    data_req = 1'b0;
    wait_idle();
    check("t2_ram_we_pulses", we_cnt - we0, 1);
    check("t2_ram_we_cycle", we_cyc, n0 + 3);
    do_txn(1'b0, 1'b0, 8'h10, 16'h0, 16'h1234);

    // 3. Both requesters held after reset: fetch, data, fetch
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = cyc;
    fetch_req = 1'b1; fetch_addr = 8'h20;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h21;
    push_gnt(1'b1, n0 + 1);  push_done(1'b1, 16'hCAFE, n0 + 4);
    push_gnt(1'b0, n0 + 6);  push_done(1'b0, 16'hF00D, n0 + 9);
    push_gnt(1'b1, n0 + 11); push_done(1'b1, 16'hCAFE, n0 + 14);
    repeat (12) @(posedge clk);
    #1;
    fetch_req = 1'b0; data_req = 1'b0;
    wait_idle();

    // 4. RAM_LAT=3 data load
    n0 = cyc;
    data_req3 = 1'b1; data_we3 = 1'b0; data_addr3 = 8'h44;
    begin
      exp_t e;
      e.is_fetch = 1'b0; e.rdata = '0; e.cyc = n0 + 1;
      gnt3_q.push_back(e);
      e.rdata = 16'h4444; e.cyc = n0 + 6;
      done3_q.push_back(e);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_gnt3) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("t4_gnt_timeout", 1, 0);
    @(posedge clk); #1;
    data_req3 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t4_busy_after", busy3, 0);
    check("t4_no_ram_we", we3_cnt, 0);

    // 5. Reset during the WAIT cycle of a store
    we0 = we_cnt;
    done0 = done_cnt;
    data_req = 1'b1; data_we = 1'b1; data_addr = 8'h55; data_wdata = 16'hABCD;
    push_gnt(1'b0, cyc + 1);
    wait_gnt(1'b0);
    @(posedge clk); #1;
    data_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy_after_rst", busy, 0);
    check("t5_outputs_after_rst", {mar_write, ram_we, fetch_done, data_done}, 4'b0);
    repeat (8) @(negedge clk);
    check("t5_no_ram_we", we_cnt - we0, 0);
    check("t5_no_done", done_cnt - done0, 0);
    check("t5_mem_untouched", mem[8'h55], 16'h5555);
    @(posedge clk); #1;

    // 6. One-cycle data_req pulse while a fetch is in flight
    dg0 = data_gnt_cnt;
    start_txn(1'b1, 1'b0, 8'h3A, 16'h0, 16'hBEEF, n0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h21;
    @(posedge clk); #1;
    data_req = 1'b0; fetch_req = 1'b0;
    wait_idle();
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_data_gnt", data_gnt_cnt - dg0, 0);

    check("gnt_queue_drained", gnt_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("gnt3_queue_drained", gnt3_q.size(), 0);
    check("done3_queue_drained", done3_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
